// File: rtl/pid_ctrl_param.sv
// Sequential PID controller: one shared multiplier steps through P, I and D terms and
// produces a saturated unsigned control value. Optional output slew limit: PID_SLEW_LIMIT_EN.
module pid_ctrl_param #(
   parameter int W        = 8,
   parameter int GAIN_W   = 8,
   parameter int FRAC     = 4,
   parameter int ACC_W    = 24,
   parameter int I_LIM    = 32767,
   parameter int KP_RST   = 32,
   parameter int KI_RST   = 0,
   parameter int KD_RST   = 0,
   parameter int SLEW_MAX = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [W-1:0]      setpoint,
   input  logic [W-1:0]      feedback,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              cfg_we,
   input  logic [1:0]        cfg_addr,
   input  logic [GAIN_W-1:0] cfg_wdata,
   input  logic              int_clr,
   output logic [W-1:0]      control_out,
   output logic              out_valid
);
   // state | meaning
   // IDLE  | waiting for a sample, in_ready high
   // ERR   | error e = setpoint - feedback
   // PTERM | acc = Kp*e
   // ITERM | integral update with clamp, acc += integral
   // DTERM | acc += Kd*(e - e_prev), e_prev <= e
   // OUT   | scale, saturate, register control_out and strobe out_valid

   localparam int EW = W + 1;
   localparam int DW = W + 2;
   localparam int PW = GAIN_W + 1 + DW;
   localparam int SW = ACC_W + 1;
   localparam int AW = ACC_W + 2;

   localparam logic signed [SW-1:0] LIM_P = SW'(I_LIM);
   localparam logic signed [SW-1:0] LIM_N = -LIM_P;
   localparam logic signed [AW-1:0] Y_MAX = AW'(2**W - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_ERR, S_PTERM, S_ITERM, S_DTERM, S_OUT
   } state_t;

   state_t state;

   logic [GAIN_W-1:0]      kp_reg, ki_reg, kd_reg;
   logic [GAIN_W-1:0]      kp_w, ki_w, kd_w;
   logic [W-1:0]           sp_q, fb_q;
   logic signed [EW-1:0]   e_q, e_prev;
   logic signed [ACC_W-1:0] integral;
   logic signed [AW-1:0]   acc;

   logic [GAIN_W-1:0]      mul_gain;
   logic signed [DW-1:0]   mul_op;
   logic signed [PW-1:0]   product;
   logic signed [EW-1:0]   e_prev_eff;
   logic signed [SW-1:0]   i_base, i_sum, i_clamp;
   logic signed [ACC_W-1:0] i_next;
   logic signed [AW-1:0]   y;
   logic [W-1:0]           y_sat, y_out;

   assign in_ready = (state == S_IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         kp_reg <= GAIN_W'(KP_RST);
         ki_reg <= GAIN_W'(KI_RST);
         kd_reg <= GAIN_W'(KD_RST);
      end else if (cfg_we) begin
         case (cfg_addr)
            2'd0:    kp_reg <= cfg_wdata;
            2'd1:    ki_reg <= cfg_wdata;
            2'd2:    kd_reg <= cfg_wdata;
            default: ;
         endcase
      end
   end

   // A clear landing on ITERM/DTERM feeds zero into this sample's arithmetic.
   always_comb begin
      e_prev_eff = int_clr ? '0 : e_prev;
      mul_gain   = kp_w;
      mul_op     = {e_q[EW-1], e_q};
      case (state)
         S_ITERM: mul_gain = ki_w;
         S_DTERM: begin
            mul_gain = kd_w;
            mul_op   = {e_q[EW-1], e_q} - {e_prev_eff[EW-1], e_prev_eff};
         end
         default: ;
      endcase
      product = $signed({1'b0, mul_gain}) * mul_op;

      i_base = int_clr ? '0 : {integral[ACC_W-1], integral};
      i_sum  = i_base + SW'(product);
      if (i_sum > LIM_P)
         i_clamp = LIM_P;
      else if (i_sum < LIM_N)
         i_clamp = LIM_N;
      else
         i_clamp = i_sum;
      i_next = i_clamp[ACC_W-1:0];
   end

   always_comb begin
      y = acc >>> FRAC;
      if (y[AW-1])
         y_sat = '0;
      else if (y > Y_MAX)
         y_sat = '1;
      else
         y_sat = y[W-1:0];
   end

`ifdef PID_SLEW_LIMIT_EN
   localparam int SL = W + 2;
   localparam logic signed [SL-1:0] SLEW_S = SL'(SLEW_MAX);
   localparam logic signed [SL-1:0] O_MAX  = SL'(2**W - 1);
   logic signed [SL-1:0] prev_s, slew_lo, slew_hi, y_s;

   always_comb begin
      prev_s  = {2'b00, control_out};
      slew_lo = prev_s - SLEW_S;
      if (slew_lo[SL-1])
         slew_lo = '0;
      slew_hi = prev_s + SLEW_S;
      if (slew_hi > O_MAX)
         slew_hi = O_MAX;
      y_s = {2'b00, y_sat};
      if (y_s > slew_hi)
         y_s = slew_hi;
      else if (y_s < slew_lo)
         y_s = slew_lo;
      y_out = y_s[W-1:0];
   end
`else
   assign y_out = y_sat;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_IDLE;
         sp_q        <= '0;
         fb_q        <= '0;
         kp_w        <= GAIN_W'(KP_RST);
         ki_w        <= GAIN_W'(KI_RST);
         kd_w        <= GAIN_W'(KD_RST);
         e_q         <= '0;
         e_prev      <= '0;
         integral    <= '0;
         acc         <= '0;
         control_out <= '0;
         out_valid   <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         if (int_clr) begin
            integral <= '0;
            e_prev   <= '0;
         end
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  sp_q  <= setpoint;
                  fb_q  <= feedback;
                  kp_w  <= kp_reg;
                  ki_w  <= ki_reg;
                  kd_w  <= kd_reg;
                  state <= S_ERR;
               end
            end
            S_ERR: begin
               e_q   <= $signed({1'b0, sp_q}) - $signed({1'b0, fb_q});
               state <= S_PTERM;
            end
            S_PTERM: begin
               acc   <= AW'(product);
               state <= S_ITERM;
            end
            S_ITERM: begin
               integral <= i_next;
               acc      <= acc + AW'(i_next);
               state    <= S_DTERM;
            end
            S_DTERM: begin
               acc    <= acc + AW'(product);
               e_prev <= e_q;
               state  <= S_OUT;
            end
            S_OUT: begin
               control_out <= y_out;
               out_valid   <= 1'b1;
               state       <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pid_ctrl_param.sv
// Self-checking bench for pid_ctrl_param: directed cases plus randomized samples
// scored against an arithmetic PID reference model.
module tb_pid_ctrl_param;
   localparam int W     = 8;
   localparam int LIM   = 320;
`ifdef PID_SLEW_LIMIT_EN
   localparam bit SLEW = 1'b1;
`else
   localparam bit SLEW = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst;
   logic [W-1:0] setpoint, feedback;
   logic         in_valid, in_ready;
   logic         cfg_we;
   logic [1:0]   cfg_addr;
   logic [7:0]   cfg_wdata;
   logic         int_clr;
   logic [W-1:0] control_out;
   logic         out_valid;

   int n_tests = 0;
   int n_fail  = 0;

   int m_kp, m_ki, m_kd, m_int, m_eprev, m_prev;

   pid_ctrl_param #(.I_LIM(LIM)) dut (
      .clk(clk), .rst(rst), .setpoint(setpoint), .feedback(feedback),
      .in_valid(in_valid), .in_ready(in_ready), .cfg_we(cfg_we),
      .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .int_clr(int_clr),
      .control_out(control_out), .out_valid(out_valid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input longint got, input longint exp);
      n_tests++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   function automatic int dc(input int v);
      return SLEW ? -1 : v;
   endfunction

   task automatic model_reset();
      m_kp = 32; m_ki = 0; m_kd = 0;
      m_int = 0; m_eprev = 0; m_prev = 0;
   endtask

   task automatic model_cfg(input int addr, input int data);
      case (addr)
         0: m_kp = data;
         1: m_ki = data;
         2: m_kd = data;
         default: ;
      endcase
   endtask

   // Whole-sample PID in plain integer arithmetic (gains are Q4.4).
   task automatic model_step(input int sp, input int fb, input bit clr, output int y);
      int e, total, lo, hi;
      if (clr) begin m_int = 0; m_eprev = 0; end
      e = sp - fb;
      m_int = m_int + m_ki * e;
      if (m_int > LIM) m_int = LIM;
      if (m_int < -LIM) m_int = -LIM;
      total = m_kp * e + m_int + m_kd * (e - m_eprev);
      m_eprev = e;
      y = total >>> 4;
      if (y < 0) y = 0;
      if (y > 255) y = 255;
      if (SLEW) begin
         lo = (m_prev - 16 < 0) ? 0 : m_prev - 16;
         hi = (m_prev + 16 > 255) ? 255 : m_prev + 16;
         if (y > hi) y = hi;
         if (y < lo) y = lo;
      end
      m_prev = y;
   endtask

   // All tasks start and end just after a falling edge.
   task automatic cfg_write(input int addr, input int data);
      cfg_we = 1'b1; cfg_addr = 2'(addr); cfg_wdata = 8'(data);
      @(negedge clk);
      cfg_we = 1'b0;
      model_cfg(addr, data);
   endtask

   task automatic clr_pulse();
      int_clr = 1'b1;
      @(negedge clk);
      int_clr = 1'b0;
      m_int = 0; m_eprev = 0;
   endtask

   task automatic run_sample(input int sp, input int fb, input bit clr, input int exp_const,
                             input bit noise, input bit mid_wr, input int mid_addr,
                             input int mid_data);
      int exp, lat, k;
      setpoint = 8'(sp); feedback = 8'(fb); in_valid = 1'b1; int_clr = clr;
      k = 0;
      while (!in_ready && k < 20) begin @(negedge clk); k++; end
      chk("ready_idle", in_ready, 1);
      model_step(sp, fb, clr, exp);
      @(negedge clk);
      in_valid = 1'b0; int_clr = 1'b0;
      chk("ready_busy", in_ready, 0);
      lat = 0;
      while (!out_valid && lat < 12) begin
         in_valid = noise && (lat >= 1) && (lat <= 3);
         setpoint = 8'($urandom); feedback = 8'($urandom);
         if (mid_wr && lat == 3) begin
            cfg_we = 1'b1; cfg_addr = 2'(mid_addr); cfg_wdata = 8'(mid_data);
         end
         @(negedge clk);
         lat++;
         if (cfg_we) begin
            cfg_we = 1'b0;
            model_cfg(mid_addr, mid_data);
         end
      end
      in_valid = 1'b0;
      chk("latency", lat, 5);
      chk("control_out", control_out, exp);
      if (exp_const >= 0) chk("directed", control_out, exp_const);
      chk("ready_after", in_ready, 1);
      @(negedge clk);
      chk("strobe_width", out_valid, 0);
   endtask

   task automatic sample(input int sp, input int fb, input int exp_const);
      run_sample(sp, fb, 1'b0, exp_const, 1'b0, 1'b0, 0, 0);
   endtask

   initial begin
      int seen;
      rst = 1'b1; in_valid = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
      int_clr = 1'b0; setpoint = '0; feedback = '0;
      model_reset();
      #12;
      chk("rst_out", control_out, 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_ready", in_ready, 1);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      if (SLEW) begin
         sample(100, 60, 16);
         sample(100, 60, 32);
         sample(100, 60, 48);
         sample(100, 60, 64);
         sample(100, 60, 80);
         sample(100, 60, 80);
      end

      sample(100, 60, dc(80));
      sample(10, 50, dc(0));
      sample(255, 0, dc(255));

      cfg_write(0, 0); cfg_write(1, 16); cfg_write(2, 0);
      clr_pulse();
      sample(20, 10, dc(10));
      sample(20, 10, dc(20));
      sample(20, 10, dc(20));
      clr_pulse();
      sample(20, 10, dc(10));

      cfg_write(1, 0); cfg_write(2, 16); cfg_write(3, 99);
      clr_pulse();
      run_sample(20, 10, 1'b0, dc(10), 1'b0, 1'b1, 2, 64);
      sample(20, 10, dc(0));
      sample(14, 10, dc(0));

      // Reset while the block sits in PTERM.
      cfg_write(0, 32);
      sample(200, 10, -1);
      setpoint = 8'd100; feedback = 8'd60; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("midrst_out", control_out, 0);
      chk("midrst_ready", in_ready, 1);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      chk("midrst_no_strobe", seen, 0);
      chk("midrst_ready2", in_ready, 1);
      sample(100, 60, dc(80));

      for (int it = 0; it < 40; it++) begin
         if ($urandom_range(1, 0) == 1)
            cfg_write($urandom_range(3, 0), $urandom_range(255, 0));
         if ($urandom_range(9, 0) == 0)
            clr_pulse();
         run_sample($urandom_range(255, 0), $urandom_range(255, 0),
                    $urandom_range(9, 0) == 0, -1, $urandom_range(2, 0) == 0,
                    $urandom_range(4, 0) == 0, $urandom_range(3, 0),
                    $urandom_range(255, 0));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/pid_ctrl_param.md
Name: pid_ctrl_param

Overview:
Parametrised, runtime-configurable successor to the fixed-gain 8-bit PID block. It takes a valid/ready-handshaked setpoint/feedback sample and computes P, I and D terms sequentially on one shared multiplier. Gains are programmable through a small config write port, and the integral has a programmable-at-elaboration clamp. The result is a saturated unsigned control value with a one-cycle valid strobe, driving the actuator-side output pins.

Parameters:
W, 8, data width of setpoint/feedback/control_out
GAIN_W, 8, unsigned gain width, fixed-point with FRAC fractional bits
FRAC, 4, fractional bits of all gains
ACC_W, 24, signed width of integral accumulator
I_LIM, 32767, integral clamp magnitude; integral held in [-I_LIM, +I_LIM]
KP_RST / KI_RST / KD_RST, 32 / 0 / 0, gain reset values (32 = 2.0 in Q4.4)
SLEW_MAX, 16, max output step per sample; used only with PID_SLEW_LIMIT_EN

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
setpoint  in  W  unsigned target
feedback  in  W  unsigned measurement
in_valid  in  1  sample present
in_ready  out  1  block idle, sample accepted when in_valid&in_ready at posedge
cfg_we  in  1  gain write strobe
cfg_addr  in  2  0=Kp, 1=Ki, 2=Kd, 3=reserved (write ignored)
cfg_wdata  in  GAIN_W  gain value
int_clr  in  1  clear integral and e_prev
control_out  out  W  saturated control value
out_valid  out  1  one-cycle strobe, control_out updated

Behaviour:
- Reset (async, rst=1): state IDLE; control_out=0; out_valid=0; integral=0; e_prev=0; gains = *_RST. in_ready=1 while in IDLE (decoded from state).
- Gain regs: written on any cycle with cfg_we. Snapshot copied into working gains at sample acceptance, so mid-computation writes affect only the next sample.
- FSM: IDLE -> ERR -> PTERM -> ITERM -> DTERM -> OUT -> IDLE. One state per cycle. in_ready=1 only in IDLE.
- Acceptance edge E0 (IDLE, in_valid=1): capture inputs and gain snapshot.
- ERR: e = setpoint - feedback, signed W+1 bits.
- PTERM: acc = Kp*e, sign-extended to ACC_W+2.
- ITERM: integral = clamp(integral + Ki*e, -I_LIM, +I_LIM); the sum is computed in ACC_W+1 bits before clamping. Then acc += integral (new value).
- DTERM: acc += Kd*(e - e_prev), delta is W+2 bits signed; then e_prev <= e.
- OUT: y = acc >>> FRAC (arithmetic); control_out = 0 if y<0, 2^W-1 if y>2^W-1, else y[W-1:0]. out_valid=1 for exactly this cycle. Output is registered, visible after edge E5.
- Latency: 5 edges from accept to out_valid. Throughput: 1 sample per 6 cycles; in_ready reasserts the cycle after OUT.
- int_clr: zeroes integral and e_prev at the next edge, in any state. If it coincides with ITERM, the cleared value is used (accumulation starts from 0 this sample). If it coincides with acceptance, the sample uses integral=0, e_prev=0.
- in_valid while busy: ignored, no buffering. Source must hold until in_ready.
- Reset mid-computation: everything returns to reset values immediately; no partial out_valid.

Optional Feature:
PID_SLEW_LIMIT_EN
- Defined: in OUT, the saturated y is further limited to control_out_prev ± SLEW_MAX, clamped within [0, 2^W-1]. control_out_prev is control_out (0 after reset).
- Undefined: no slew limit; SLEW_MAX unused; saturated y is output directly.

Test Plan:
- Defaults (Kp=32), sp=100 fb=60 -> e=40, out_valid 5 edges after accept, control_out=80; in_ready low during compute.
- Kp=32, sp=10 fb=50 -> control_out=0. sp=255 fb=0 -> control_out=255 (saturation both ways).
- cfg Kp=0, Ki=16, Kd=0, I_LIM=320; three samples sp=20 fb=10 -> control_out 10, 20, 20 (integral clamped). Then int_clr pulse, one more sample -> 10.
- cfg Kp=0, Ki=0, Kd=16; samples e=10, 10, 4 -> control_out 10, 0, 0 (third is -6, clamped to 0). Kd write during DTERM does not change the current result.
- Assert rst during PTERM -> out_valid stays 0, control_out=0, in_ready=1 after release; next sample gives correct result from zero state.
- With PID_SLEW_LIMIT_EN, SLEW_MAX=16, Kp=32, sp=100 fb=60 repeated -> control_out 16, 32, 48, 64, 80, 80.
